// File: rtl/ili9341_pkg.sv
// Shared ILI9341 opcodes, window/coordinate sizing and tracker state encoding.
package ili9341_pkg;

    localparam logic [7:0] OP_SWRESET = 8'h01;
    localparam logic [7:0] OP_CASET   = 8'h2A;
    localparam logic [7:0] OP_PASET   = 8'h2B;
    localparam logic [7:0] OP_RAMWR   = 8'h2C;

    // 9-bit coordinates cover panels up to 512 pixels on a side.
    localparam int COORD_W = 9;

    typedef logic [2:0] trk_state_t;
    localparam trk_state_t ST_IDLE  = 3'd0;
    localparam trk_state_t ST_CASET = 3'd1;
    localparam trk_state_t ST_PASET = 3'd2;
    localparam trk_state_t ST_RAMWR = 3'd3;
    localparam trk_state_t ST_OTHER = 3'd4;

    // A window is accepted only when it is ordered and its end lies inside the panel.
    function automatic logic win_ok(input logic [15:0] lo, input logic [15:0] hi,
                                    input logic [15:0] lim);
        return (lo <= hi) && (hi < lim);
    endfunction

endpackage

// File: rtl/ili9341_spi_rx_if.sv
// SPI pins from the host plus the decoded byte/pixel stream of the receiver.
interface ili9341_spi_rx_if;
    import ili9341_pkg::*;

    logic               tft_cs;
    logic               tft_clk;
    logic               tft_dc;
    logic               tft_din;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_is_cmd;
    logic               pix_valid;
    logic [15:0]        pix_data;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [7:0]         cur_cmd;

    modport master (
        output tft_cs, tft_clk, tft_dc, tft_din,
        input  byte_valid, byte_data, byte_is_cmd,
        input  pix_valid, pix_data, pix_x, pix_y, cur_cmd
    );

    modport slave (
        input  tft_cs, tft_clk, tft_dc, tft_din,
        output byte_valid, byte_data, byte_is_cmd,
        output pix_valid, pix_data, pix_x, pix_y, cur_cmd
    );

endinterface

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into sysclk and flags tft_clk rising edges.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic rst,
    input  logic tft_cs,
    input  logic tft_clk,
    input  logic tft_dc,
    input  logic tft_din,
    output logic cs_s,
    output logic dc_s,
    output logic din_s,
    output logic sck_rise
);

    localparam int NUM_LANES = 4;
    // Chip select comes out of reset deasserted so no bits are taken early.
    localparam logic [NUM_LANES-1:0] RST_VAL = 4'b0001;

    logic [NUM_LANES-1:0] raw;
    logic [NUM_LANES-1:0] synced;
    logic                 sck_q;

    assign raw = {tft_din, tft_dc, tft_clk, tft_cs};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [SYNC_STAGES-1:0] q;
        always_ff @(posedge sysclk or posedge rst) begin
            if (rst) begin
                q <= {SYNC_STAGES{RST_VAL[l]}};
            end else begin
                q[0] <= raw[l];
                for (int s = 1; s < SYNC_STAGES; s++) q[s] <= q[s-1];
            end
        end
        assign synced[l] = q[SYNC_STAGES-1];
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) sck_q <= 1'b0;
        else     sck_q <= synced[1];
    end

    assign cs_s     = synced[0];
    assign dc_s     = synced[2];
    assign din_s    = synced[3];
    assign sck_rise = synced[1] & ~sck_q;

endmodule

// File: rtl/ili9341_spi_rx.sv
// ILI9341 SPI sniffer: deserialises bytes, tracks CASET/PASET/RAMWR and emits
// RGB565 pixels with their panel coordinates.
module ili9341_spi_rx
    import ili9341_pkg::*;
#(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sysclk,
    input  logic             rst,
    ili9341_spi_rx_if.slave  bus
);

    localparam int                 STAGES = 1;
    localparam logic [15:0]        W_LIM  = 16'(WIDTH);
    localparam logic [15:0]        H_LIM  = 16'(HEIGHT);
    localparam logic [COORD_W-1:0] XE_RST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] YE_RST = COORD_W'(HEIGHT - 1);

    logic cs_s, dc_s, din_s, sck_rise;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sysclk   (sysclk),
        .rst      (rst),
        .tft_cs   (bus.tft_cs),
        .tft_clk  (bus.tft_clk),
        .tft_dc   (bus.tft_dc),
        .tft_din  (bus.tft_din),
        .cs_s     (cs_s),
        .dc_s     (dc_s),
        .din_s    (din_s),
        .sck_rise (sck_rise)
    );

    // ---------------- byte deserialiser ----------------
    logic [2:0]      bit_cnt;
    logic [6:0]      shreg;
    logic [STAGES:0] vld_pipe;
    logic [7:0]      rx_byte;
    logic            rx_cmd;
    logic [7:0]      byte_data;
    logic            byte_is_cmd;

    assign rx_byte     = {shreg, din_s};
    assign rx_cmd      = ~dc_s;
    assign vld_pipe[0] = sck_rise & ~cs_s & (bit_cnt == 3'd7);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (cs_s) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            shreg   <= {shreg[5:0], din_s};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            byte_data          <= '0;
            byte_is_cmd        <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[0]) begin
                byte_data   <= rx_byte;
                byte_is_cmd <= rx_cmd;
            end
        end
    end

    // ---------------- command tracker ----------------
    trk_state_t         state;
    logic [7:0]         cur_cmd;
    logic [2:0]         arg_idx;
    logic [2:0][7:0]    arg_sh;
    logic [COORD_W-1:0] xs, xe, ys, ye, cx, cy;
    logic               half;
    logic [7:0]         hi_byte;
    logic               pix_valid;
    logic [15:0]        pix_data;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic [15:0]        win_lo, win_hi;

    // The 4th argument byte is still on the wire, so the end value uses it directly.
    assign win_lo = {arg_sh[0], arg_sh[1]};
    assign win_hi = {arg_sh[2], rx_byte};

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_cmd   <= '0;
            arg_idx   <= '0;
            arg_sh    <= '0;
            xs        <= '0;
            xe        <= XE_RST;
            ys        <= '0;
            ye        <= YE_RST;
            cx        <= '0;
            cy        <= '0;
            half      <= 1'b0;
            hi_byte   <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (vld_pipe[0] && rx_cmd) begin
                cur_cmd <= rx_byte;
                arg_idx <= '0;
                half    <= 1'b0;
                case (rx_byte)
                    OP_CASET: state <= ST_CASET;
                    OP_PASET: state <= ST_PASET;
                    OP_RAMWR: begin
                        state <= ST_RAMWR;
                        cx    <= xs;
                        cy    <= ys;
                    end
                    OP_SWRESET: begin
                        state <= ST_IDLE;
                        xs    <= '0;
                        xe    <= XE_RST;
                        ys    <= '0;
                        ye    <= YE_RST;
                    end
                    default: state <= ST_OTHER;
                endcase
            end else if (vld_pipe[0]) begin
                case (state)
                    ST_CASET, ST_PASET: begin
                        if (arg_idx < 3'd4) begin
                            arg_idx <= arg_idx + 3'd1;
                            if (arg_idx != 3'd3) begin
                                arg_sh[arg_idx[1:0]] <= rx_byte;
                            end else if (state == ST_CASET) begin
                                if (win_ok(win_lo, win_hi, W_LIM)) begin
                                    xs <= win_lo[COORD_W-1:0];
                                    xe <= win_hi[COORD_W-1:0];
                                end
                            end else if (win_ok(win_lo, win_hi, H_LIM)) begin
                                ys <= win_lo[COORD_W-1:0];
                                ye <= win_hi[COORD_W-1:0];
                            end
                        end
                    end
                    ST_RAMWR: begin
                        if (!half) begin
                            hi_byte <= rx_byte;
                            half    <= 1'b1;
                        end else begin
                            half      <= 1'b0;
                            pix_valid <= 1'b1;
                            pix_data  <= {hi_byte, rx_byte};
                            pix_x     <= cx;
                            pix_y     <= cy;
                            // Raster advance inside the window, wrapping to its origin.
                            if (cx == xe) begin
                                cx <= xs;
                                cy <= (cy == ye) ? ys : cy + 1'b1;
                            end else begin
                                cx <= cx + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_valid  = vld_pipe[STAGES];
    assign bus.byte_data   = byte_data;
    assign bus.byte_is_cmd = byte_is_cmd;
    assign bus.pix_valid   = pix_valid;
    assign bus.pix_data    = pix_data;
    assign bus.pix_x       = pix_x;
    assign bus.pix_y       = pix_y;
    assign bus.cur_cmd     = cur_cmd;

endmodule

// File: tb/tb_ili9341_spi_rx.sv
// Bench for ili9341_spi_rx: vector table, directed window/pixel sequences and a
// randomized command stream scored against a window-arithmetic reference model.
module tb_ili9341_spi_rx;

    localparam int W = 240;
    localparam int H = 320;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    ili9341_spi_rx_if bus();

    ili9341_spi_rx #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    typedef struct { logic [7:0] d; logic c; } bev_t;
    typedef struct { logic [15:0] d; int x; int y; } pev_t;
    typedef struct { logic [7:0] b; logic dc; logic [7:0] ed; logic ec; logic [7:0] ecur; } vec_t;

    bev_t got_b[$], exp_b[$];
    pev_t got_p[$], exp_p[$];
    int   rb = 0, rp = 0, viol = 0;
    int   ntest = 0, nfail = 0;

    always @(negedge sysclk) begin
        if (!rst) begin
            if (bus.byte_valid) got_b.push_back('{bus.byte_data, bus.byte_is_cmd});
            if (bus.pix_valid) begin
                got_p.push_back('{bus.pix_data, int'(bus.pix_x), int'(bus.pix_y)});
                if (!bus.byte_valid) viol++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_xs, m_xe, m_ys, m_ye, m_mode, m_pixn;
    logic [7:0] m_cur, m_hi;
    bit         m_have_hi, use_mdl = 0;
    logic [7:0] m_args[$];

    task automatic mdl_reset();
        m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1;
        m_mode = 0; m_pixn = 0; m_cur = 8'h00; m_have_hi = 0;
        m_args.delete();
    endtask

    task automatic mdl_byte(input logic [7:0] b, input logic dc);
        int s, e, w, h;
        if (!dc) begin
            m_cur = b; m_args.delete(); m_have_hi = 0; m_pixn = 0;
            case (b)
                8'h2A:   m_mode = 1;
                8'h2B:   m_mode = 2;
                8'h2C:   m_mode = 3;
                8'h01:   begin m_mode = 0; m_xs = 0; m_xe = W - 1; m_ys = 0; m_ye = H - 1; end
                default: m_mode = 4;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            if (m_args.size() < 4) begin
                m_args.push_back(b);
                if (m_args.size() == 4) begin
                    s = {m_args[0], m_args[1]};
                    e = {m_args[2], m_args[3]};
                    if (m_mode == 1 && s <= e && e < W) begin m_xs = s; m_xe = e; end
                    if (m_mode == 2 && s <= e && e < H) begin m_ys = s; m_ye = e; end
                end
            end
        end else if (m_mode == 3) begin
            if (!m_have_hi) begin
                m_hi = b; m_have_hi = 1;
            end else begin
                w = m_xe - m_xs + 1;
                h = m_ye - m_ys + 1;
                exp_p.push_back('{{m_hi, b}, m_xs + m_pixn % w, m_ys + (m_pixn / w) % h});
                m_pixn++;
                m_have_hi = 0;
            end
        end
    endtask

    // ---------------- pin drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        for (int i = 0; i < n; i++) begin
            bus.tft_din = b[7-i];
            bus.tft_dc  = dc;
            tick(4);
            bus.tft_clk = 1'b1;
            tick(4);
            bus.tft_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, 8, dc);
        exp_b.push_back('{b, ~dc});
        if (use_mdl) mdl_byte(b, dc);
    endtask

    task automatic data4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        send_byte(a, 1'b1); send_byte(b, 1'b1); send_byte(c, 1'b1); send_byte(d, 1'b1);
    endtask

    task automatic pix(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(hi, 1'b1); send_byte(lo, 1'b1);
    endtask

    task automatic cs_low();  bus.tft_cs = 1'b0; tick(4); endtask
    task automatic cs_high(); bus.tft_cs = 1'b1; tick(6); endtask

    task automatic cmp(input string nm, input int cur);
        tick(16);
        chk({nm, " byte count"}, got_b.size() - rb, exp_b.size());
        for (int i = 0; i < exp_b.size() && rb + i < got_b.size(); i++) begin
            chk({nm, " byte_data"},   got_b[rb+i].d, exp_b[i].d);
            chk({nm, " byte_is_cmd"}, got_b[rb+i].c, exp_b[i].c);
        end
        rb = got_b.size(); exp_b.delete();
        chk({nm, " pix count"}, got_p.size() - rp, exp_p.size());
        for (int i = 0; i < exp_p.size() && rp + i < got_p.size(); i++) begin
            chk({nm, " pix_data"}, got_p[rp+i].d, exp_p[i].d);
            chk({nm, " pix_x"},    got_p[rp+i].x, exp_p[i].x);
            chk({nm, " pix_y"},    got_p[rp+i].y, exp_p[i].y);
        end
        rp = got_p.size(); exp_p.delete();
        chk({nm, " cur_cmd"}, bus.cur_cmd, cur);
    endtask

    function automatic logic [15:0] pick(input int lim);
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 7));
            1:       return 16'(lim - int'($urandom_range(1, 4)));
            2:       return 16'(lim + int'($urandom_range(0, 2)));
            default: return 16'($urandom_range(0, lim - 1));
        endcase
    endfunction

    vec_t tbl[6];

    initial begin
        logic [7:0]  c;
        logic [15:0] s, e;
        int          n, k;

        tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b1, 8'hA5};
        tbl[1] = '{8'h3C, 1'b1, 8'h3C, 1'b0, 8'hA5};
        tbl[2] = '{8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 8'h00};
        tbl[4] = '{8'h81, 1'b0, 8'h81, 1'b1, 8'h81};
        tbl[5] = '{8'h01, 1'b0, 8'h01, 1'b1, 8'h01};

        bus.tft_cs = 1'b1; bus.tft_clk = 1'b0; bus.tft_dc = 1'b0; bus.tft_din = 1'b0;
        tick(3);
        chk("reset byte_valid",  bus.byte_valid, 0);
        chk("reset pix_valid",   bus.pix_valid, 0);
        chk("reset byte_is_cmd", bus.byte_is_cmd, 0);
        chk("reset byte_data",   bus.byte_data, 0);
        chk("reset pix_data",    bus.pix_data, 0);
        chk("reset pix_x",       bus.pix_x, 0);
        chk("reset pix_y",       bus.pix_y, 0);
        chk("reset cur_cmd",     bus.cur_cmd, 0);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 6; i++) begin
            cs_low();
            send_byte(tbl[i].b, tbl[i].dc);
            cs_high();
            cmp("tbl", tbl[i].ecur);
            chk("tbl held byte_data", bus.byte_data, tbl[i].ed);
            chk("tbl held is_cmd",    bus.byte_is_cmd, tbl[i].ec);
        end

        // 2x2 window at (16,32), four red pixels raster-ordered
        cs_low();
        send_byte(8'h2A, 1'b0); data4(8'h00, 8'h10, 8'h00, 8'h11);
        send_byte(8'h2B, 1'b0); data4(8'h00, 8'h20, 8'h00, 8'h21);
        send_byte(8'h2C, 1'b0);
        repeat (4) pix(8'hF8, 8'h00);
        exp_p.push_back('{16'hF800, 16, 32});
        exp_p.push_back('{16'hF800, 17, 32});
        exp_p.push_back('{16'hF800, 16, 33});
        exp_p.push_back('{16'hF800, 17, 33});
        cmp("window fill", 8'h2C);

        pix(8'h07, 8'hE0);
        exp_p.push_back('{16'h07E0, 16, 32});
        cmp("window wrap", 8'h2C);

        // partial byte dropped by CS deassertion
        cs_high(); cs_low();
        send_bits(8'hB7, 5, 1'b1);
        cs_high(); cs_low();
        send_byte(8'h3C, 1'b1);
        cmp("cs abort", 8'h2C);
        chk("cs abort byte_data", bus.byte_data, 8'h3C);

        // reversed column window is rejected
        send_byte(8'h2A, 1'b0); data4(8'h00, 8'h20, 8'h00, 8'h10);
        send_byte(8'h2C, 1'b0);
        pix(8'h12, 8'h34);
        exp_p.push_back('{16'h1234, 16, 32});
        cmp("bad window", 8'h2C);

        // reset after a pending high byte
        send_byte(8'hAB, 1'b1);
        cmp("pending hi", 8'h2C);
        rst = 1'b1;
        tick(2);
        chk("midrst pix_x",     bus.pix_x, 0);
        chk("midrst pix_data",  bus.pix_data, 0);
        chk("midrst byte_data", bus.byte_data, 0);
        chk("midrst cur_cmd",   bus.cur_cmd, 0);
        rst = 1'b0;
        tick(6);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        cmp("post reset data", 8'h00);
        cs_high();

        // randomized command stream against the model
        rst = 1'b1; tick(2); rst = 1'b0; tick(4);
        mdl_reset();
        use_mdl = 1;
        cs_low();
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 6);
            case (k)
                0, 1: begin
                    s = pick(k == 0 ? W : H);
                    e = ($urandom_range(0, 4) == 0) ? s - 16'd1 : s + 16'($urandom_range(0, 3));
                    n = $urandom_range(3, 5);
                    send_byte(k == 0 ? 8'h2A : 8'h2B, 1'b0);
                    if (n > 0) send_byte(s[15:8], 1'b1);
                    if (n > 1) send_byte(s[7:0], 1'b1);
                    if (n > 2) send_byte(e[15:8], 1'b1);
                    if (n > 3) send_byte(e[7:0], 1'b1);
                    if (n > 4) send_byte(8'($urandom), 1'b1);
                end
                2: begin
                    send_byte(8'h2C, 1'b0);
                    repeat ($urandom_range(0, 9)) send_byte(8'($urandom), 1'b1);
                end
                3: begin
                    do c = 8'($urandom);
                    while (c == 8'h01 || c == 8'h2A || c == 8'h2B || c == 8'h2C);
                    send_byte(c, 1'b0);
                    repeat ($urandom_range(0, 3)) send_byte(8'($urandom), 1'b1);
                end
                4: send_byte(8'h01, 1'b0);
                5: begin
                    send_bits(8'($urandom), $urandom_range(1, 7), 1'($urandom));
                    cs_high(); cs_low();
                end
                default: repeat ($urandom_range(1, 4)) send_byte(8'($urandom), 1'b1);
            endcase
            cmp("random", m_cur);
        end
        cs_high();

        chk("pix_valid without byte_valid", viol, 0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/ili9341_spi_rx.md
ILI9341_SPI_RX -- requirements
Module: ili9341_spi_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 240, panel columns.
REQ-002 SHALL have parameter HEIGHT, default 320, panel rows.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for the SPI inputs.
REQ-004 SHALL have port sysclk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tft_cs  input  1  chip select, active-low.
REQ-007 SHALL have port tft_clk  input  1  SPI clock from the host driver; data sampled on its rising edge.
REQ-008 SHALL have port tft_dc  input  1  0 = command byte, 1 = data byte.
REQ-009 SHALL have port tft_din  input  1  serial data, MSB first.
REQ-010 SHALL have port byte_valid  output  1  one-cycle strobe per received byte.
REQ-011 SHALL have port byte_data  output  8  received byte, held until the next strobe.
REQ-012 SHALL have port byte_is_cmd  output  1  1 when the byte was a command.
REQ-013 SHALL have port pix_valid  output  1  one-cycle strobe per assembled RGB565 pixel.
REQ-014 SHALL have port pix_data  output  16  pixel value.
REQ-015 SHALL have port pix_x  output  9  and pix_y  output  9  pixel coordinates.
REQ-016 SHALL have port cur_cmd  output  8  last command opcode received.

Function
REQ-017 SHALL pass tft_cs, tft_clk, tft_dc and tft_din through SYNC_STAGES flops and detect tft_clk rising edges on the synchronized copy; tft_clk frequency SHALL be at most sysclk/4.
REQ-018 SHALL, on each detected edge with tft_cs low, shift tft_din into the byte register MSB-first and increment a 3-bit bit counter.
REQ-019 SHALL, on the 8th bit, pulse byte_valid on the next cycle, with byte_data = shifted byte and byte_is_cmd = ~tft_dc as sampled with bit 0.
REQ-020 SHALL clear the bit counter and discard any partial byte whenever synchronized tft_cs is high.
REQ-021 SHALL run a tracker FSM with states IDLE, CASET, PASET, RAMWR, OTHER; any command byte sets cur_cmd and transitions as follows: 0x2A -> CASET, 0x2B -> PASET, 0x2C -> RAMWR, 0x01 -> IDLE with window restored to reset values, any other opcode -> OTHER.
REQ-022 SHALL, in CASET, collect data bytes XS[15:8], XS[7:0], XE[15:8], XE[7:0] into a shadow; on the 4th byte commit the column window only if XS <= XE and XE < WIDTH, else retain the previous window; bytes beyond the 4th are ignored.
REQ-023 SHALL apply REQ-022 identically in PASET for YS/YE against HEIGHT.
REQ-024 SHALL, on entering RAMWR, load cursor x = XS, y = YS and clear the pixel half-flag.
REQ-025 SHALL, in RAMWR, treat data bytes as pairs (high then low); on the low byte pulse pix_valid in the same cycle as byte_valid with pix_data = {high, low} and pix_x/pix_y = cursor.
REQ-026 SHALL advance the cursor after each pixel: x+1; if x == XE then x = XS and y+1; if additionally y == YE then y = YS (wrap to window origin).
REQ-027 SHALL discard a pending high byte when a command byte arrives mid-pixel.
REQ-028 SHALL ignore data bytes in IDLE and OTHER (byte_valid still pulses, pix_valid does not).
REQ-029 SHALL never assert byte_valid and pix_valid for different bytes in the same cycle.

Reset
REQ-030 SHALL, while rst is high, hold byte_valid, pix_valid, byte_is_cmd at 0, byte_data, pix_data, pix_x, pix_y, cur_cmd at 0, FSM in IDLE, bit counter 0.
REQ-031 SHALL reset the window to XS = 0, XE = WIDTH-1, YS = 0, YE = HEIGHT-1; a reset mid-transfer SHALL drop the partial byte and pixel.

Structure
REQ-032 SHALL take opcodes (SWRESET 0x01, CASET 0x2A, PASET 0x2B, RAMWR 0x2C) and the tracker state typedef from shared package ili9341_pkg.
REQ-033 SHALL instantiate one sub-module, spi_edge_sync, containing the input synchronizers and tft_clk rising-edge detector.

Verification
REQ-034 CS low, DC low, shift 0xA5 -> exactly one byte_valid, byte_data = 0xA5, byte_is_cmd = 1, cur_cmd = 0xA5.
REQ-035 CASET 00 10 00 11, PASET 00 20 00 21, RAMWR, data F8 00 x4 -> pix_valid x4 at (16,32), (17,32), (16,33), (17,33), pix_data = 0xF800.
REQ-036 Continue REQ-035 with a fifth pixel 0x07E0 -> pix at (16,32), pix_data = 0x07E0.
REQ-037 5 bits then CS high, then CS low and byte 0x3C -> one byte_valid only, byte_data = 0x3C.
REQ-038 CASET 00 20 00 10 after REQ-035 window, RAMWR, one pixel -> pixel at (16,32) (window unchanged).
REQ-039 rst pulse mid-RAMWR after a high byte, then two data bytes with no command -> two byte_valid, no pix_valid, cur_cmd = 0.
